// File: rtl/floatingpoint_divider_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division, one quotient bit per clock.
// Optional macro FPDIV_SPECIAL_EN adds zero/inf/NaN operand classification that bypasses DIV.
module floatingpoint_divider_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int Q_BITS     = 25
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] dataA_i,
  input  logic [DATA_WIDTH-1:0] dataB_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int CNT_W = $clog2(Q_BITS);

  typedef enum logic [1:0] {IDLE, DIV, NORM, OUT} state_e;

  state_e                 state_q, state_d;
  logic                   sign_q, sign_d;
  logic signed [9:0]      expDiff_q, expDiff_d;
  logic [25:0]            rem_q, rem_d;
  logic [23:0]            divisor_q, divisor_d;
  logic [Q_BITS-1:0]      quot_q, quot_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   special_q, special_d;
  logic [DATA_WIDTH-1:0]  specialRes_q, specialRes_d;

  logic                   specialHit;
  logic [DATA_WIDTH-1:0]  specialWord;
  logic [25:0]            remSub;
  logic [22:0]            normMant;
  logic signed [9:0]      normExp;

`ifdef FPDIV_SPECIAL_EN
  logic aZero, bZero, aInf, bInf, aNan, bNan, resSign;

  // Denormals count as zero; exponent 255 splits into inf/NaN by mantissa.
  always_comb begin
    aZero      = (dataA_i[30:23] == 8'h00);
    bZero      = (dataB_i[30:23] == 8'h00);
    aInf       = (dataA_i[30:23] == 8'hFF) && (dataA_i[22:0] == 23'h0);
    bInf       = (dataB_i[30:23] == 8'hFF) && (dataB_i[22:0] == 23'h0);
    aNan       = (dataA_i[30:23] == 8'hFF) && (dataA_i[22:0] != 23'h0);
    bNan       = (dataB_i[30:23] == 8'hFF) && (dataB_i[22:0] != 23'h0);
    resSign    = dataA_i[31] ^ dataB_i[31];
    specialHit = aZero | bZero | aInf | bInf | aNan | bNan;
    if (aNan || bNan || (aZero && bZero) || (aInf && bInf)) begin
      specialWord = 32'h7FC00000;
    end else if (bZero || aInf) begin
      specialWord = {resSign, 8'hFF, 23'h0};
    end else begin
      specialWord = {resSign, 31'h0};
    end
  end
`else
  assign specialHit  = 1'b0;
  assign specialWord = '0;
`endif

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    expDiff_d    = expDiff_q;
    rem_d        = rem_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    valid_d      = valid_q;
    special_d    = special_q;
    specialRes_d = specialRes_q;
    remSub       = rem_q;
    normMant     = '0;
    normExp      = '0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          sign_d       = dataA_i[31] ^ dataB_i[31];
          expDiff_d    = $signed({2'b00, dataA_i[30:23]}) - $signed({2'b00, dataB_i[30:23]});
          rem_d        = {2'b00, 1'b1, dataA_i[22:0]};
          divisor_d    = {1'b1, dataB_i[22:0]};
          quot_d       = '0;
          cnt_d        = CNT_W'(Q_BITS - 1);
          special_d    = specialHit;
          specialRes_d = specialWord;
          state_d      = specialHit ? NORM : DIV;
        end
      end
      DIV: begin
        if (rem_q >= {2'b00, divisor_q}) begin
          quot_d[cnt_q] = 1'b1;
          remSub        = rem_q - {2'b00, divisor_q};
        end
        rem_d = remSub << 1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = NORM;
        end
      end
      NORM: begin
        // Quotient lies in [0.5, 2): pick the leading one and bias accordingly, truncating.
        if (quot_q[24]) begin
          normMant = quot_q[23:1];
          normExp  = expDiff_q + 10'sd127;
        end else begin
          normMant = quot_q[22:0];
          normExp  = expDiff_q + 10'sd126;
        end
        if (special_q) begin
          data_d = specialRes_q;
        end else if (normExp >= 10'sd255) begin
          data_d = {sign_q, 8'hFF, 23'h0};
        end else if (normExp <= 10'sd0) begin
          data_d = {sign_q, 31'h0};
        end else begin
          data_d = {sign_q, normExp[7:0], normMant};
        end
        valid_d = 1'b1;
        state_d = OUT;
      end
      OUT: begin
        if (ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      sign_q       <= 1'b0;
      expDiff_q    <= '0;
      rem_q        <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      special_q    <= 1'b0;
      specialRes_q <= '0;
    end else begin
      state_q      <= state_d;
      sign_q       <= sign_d;
      expDiff_q    <= expDiff_d;
      rem_q        <= rem_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      special_q    <= special_d;
      specialRes_q <= specialRes_d;
    end
  end

  assign ready_o = (state_q == IDLE);
  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_floatingpoint_divider_seq.sv
// Scoreboard bench for floatingpoint_divider_seq: integer-arithmetic reference model,
// directed corner cases, backpressure, mid-operation reset and randomized operands.
module tb_floatingpoint_divider_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] dataA_i, dataB_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;

  floatingpoint_divider_seq #(.DATA_WIDTH(32), .Q_BITS(25)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .dataA_i(dataA_i),
    .dataB_i(dataB_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .valid_o(valid_o),
    .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] word;
    int          acceptEdge;
    int          lat;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sbQ[$];
  exp_t cur;
  int   checkCount = 0;
  int   errorCount = 0;
  int   edgeCount  = 0;
  logic prevValid  = 1'b0;

  always @(posedge clk_i) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act !== expv) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  // Reference: quotient as an exact integer floor, then IEEE packing with saturation.
  function automatic void refDivide(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output int lat);
    longint ma, mb, q;
    int     e;
    logic   s;
`ifdef FPDIV_SPECIAL_EN
    bit aZ, bZ, aI, bI, aN, bN;
`endif
    s   = a[31] ^ b[31];
    lat = 27;
`ifdef FPDIV_SPECIAL_EN
    aZ = (a[30:23] == 8'h00);
    bZ = (b[30:23] == 8'h00);
    aI = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    bI = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    aN = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    bN = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    if (aZ || bZ || aI || bI || aN || bN) begin
      lat = 2;
      if (aN || bN || (aZ && bZ) || (aI && bI)) res = 32'h7FC00000;
      else if (bZ || aI)                        res = {s, 8'hFF, 23'h0};
      else                                      res = {s, 31'h0};
      return;
    end
`endif
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    if (ma >= mb) begin
      q = (ma <<< 23) / mb;
      e = int'(a[30:23]) - int'(b[30:23]) + 127;
    end else begin
      q = (ma <<< 24) / mb;
      e = int'(a[30:23]) - int'(b[30:23]) + 126;
    end
    if (e >= 255)     res = {s, 8'hFF, 23'h0};
    else if (e <= 0)  res = {s, 31'h0};
    else              res = {s, e[7:0], q[22:0]};
  endfunction

  // Monitor: every rising valid_o is one result; pop and compare value and latency.
  always @(negedge clk_i) begin
    if (rst_ni && valid_o && !prevValid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedValid", {31'b0, valid_o}, 32'd0);
      end else begin
        cur = sbQ.pop_front();
        checkOutput($sformatf("result %h/%h", cur.a, cur.b), data_o, cur.word);
        checkOutput($sformatf("latency %h/%h", cur.a, cur.b), 32'(edgeCount - cur.acceptEdge + 1),
                    32'(cur.lat));
      end
    end
    prevValid = valid_o;
  end

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input bit track);
    exp_t e;
    int   waitCnt;
    waitCnt = 0;
    @(negedge clk_i);
    while (!ready_o && waitCnt < 200) begin
      @(negedge clk_i);
      waitCnt++;
    end
    if (!ready_o) begin
      checkOutput("readyTimeout", {31'b0, ready_o}, 32'd1);
      return;
    end
    dataA_i = a;
    dataB_i = b;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    if (track) begin
      e.a          = a;
      e.b          = b;
      e.acceptEdge = edgeCount;
      refDivide(a, b, e.word, e.lat);
      sbQ.push_back(e);
    end
    @(negedge clk_i);
    valid_i = 1'b0;
    dataA_i = $urandom;
    dataB_i = $urandom;
  endtask

  task automatic waitDrain();
    int waitCnt;
    waitCnt = 0;
    while ((sbQ.size() != 0 || valid_o) && waitCnt < 100) begin
      @(negedge clk_i);
      waitCnt++;
    end
    checkOutput("drainPending", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, b, bpExp;
    int          bpLat, waitCnt;

    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    dataA_i = '0;
    dataB_i = '0;
    repeat (3) @(negedge clk_i);
    checkOutput("resetValid", {31'b0, valid_o}, 32'd0);
    checkOutput("resetData", data_o, 32'd0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    checkOutput("readyAfterReset", {31'b0, ready_o}, 32'd1);

    applyStimulus(32'h40C00000, 32'h40000000, 1'b1);
    applyStimulus(32'h3F800000, 32'h40400000, 1'b1);
    applyStimulus(32'hC0F00000, 32'h40200000, 1'b1);
    applyStimulus(32'h7E800000, 32'h00800000, 1'b1);
    applyStimulus(32'h00800000, 32'h7E800000, 1'b1);
    waitDrain();

    // Backpressure: result must hold while ready_i is low and new requests are ignored.
    ready_i = 1'b0;
    refDivide(32'h40C00000, 32'h40000000, bpExp, bpLat);
    applyStimulus(32'h40C00000, 32'h40000000, 1'b1);
    waitCnt = 0;
    while (!valid_o && waitCnt < 60) begin
      @(negedge clk_i);
      waitCnt++;
    end
    checkOutput("bpValidSeen", {31'b0, valid_o}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      dataA_i = $urandom;
      dataB_i = $urandom;
      valid_i = 1'b1;
      @(negedge clk_i);
      checkOutput("bpValidHold", {31'b0, valid_o}, 32'd1);
      checkOutput("bpDataHold", data_o, bpExp);
      checkOutput("bpReadyLow", {31'b0, ready_o}, 32'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    checkOutput("bpReadyAfter", {31'b0, ready_o}, 32'd1);
    checkOutput("bpValidAfter", {31'b0, valid_o}, 32'd0);

    // Reset in the middle of a division must discard it.
    applyStimulus(32'h3F800000, 32'h40400000, 1'b0);
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    checkOutput("midResetValid", {31'b0, valid_o}, 32'd0);
    checkOutput("midResetData", data_o, 32'd0);
    checkOutput("midResetReady", {31'b0, ready_o}, 32'd1);
    rst_ni = 1'b1;
    applyStimulus(32'h40C00000, 32'h40000000, 1'b1);
    waitDrain();

`ifdef FPDIV_SPECIAL_EN
    applyStimulus(32'h3F800000, 32'h00000000, 1'b1);
    applyStimulus(32'h00000000, 32'h00000000, 1'b1);
    applyStimulus(32'h7F800000, 32'h7F800000, 1'b1);
    applyStimulus(32'hC0000000, 32'h7F800000, 1'b1);
    waitDrain();
`endif

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) begin
        a = $urandom;
        b = $urandom;
      end else begin
        a = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
        b = {1'($urandom), 8'($urandom_range(254, 1)), 23'($urandom)};
      end
      applyStimulus(a, b, 1'b1);
    end
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
